// File: rtl/mux_latch_bank.sv
// Bank of up to four mux/xor/latch channels with a serially loaded, double-buffered config.
// Define LATCH_DEBOUNCE_EN to require two consecutive qualifying samples before latching.
module mux_latch_bank #(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned CfgW = 3 * CHANNELS;

`ifdef LATCH_DEBOUNCE_EN
  localparam logic DebounceEn = 1'b1;
`else
  localparam logic DebounceEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StArmed, StLatched} state_e;

  logic clk, rst, a, b, cfg_bit, cfg_shift, cfg_commit, clear;
  assign clk        = io_in[0];
  assign rst        = io_in[1];
  assign a          = io_in[2];
  assign b          = io_in[3];
  assign cfg_bit    = io_in[4];
  assign cfg_shift  = io_in[5];
  assign cfg_commit = io_in[6];
  assign clear      = io_in[7];

  logic [CfgW-1:0] shadow_q, shadow_d, active_q, active_d;
  logic            shift_prev_q, commit_prev_q;
  logic            pending_q, pending_d;
  logic            x0_q, evt_tgl_q, evt_tgl_d, any_q, any_d;
  state_e          state_q [CHANNELS];
  state_e          state_d [CHANNELS];
  logic [CHANNELS-1:0] x;
  logic [3:0]      flag;
  logic            shift_edge, commit_edge;

  assign shift_edge  = cfg_shift & ~shift_prev_q;
  assign commit_edge = cfg_commit & ~commit_prev_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_x
    assign x[i] = (active_q[3*i] ? b : a) ^ active_q[3*i+1];
  end

  for (genvar i = 0; i < 4; i++) begin : g_flag
    if (i < CHANNELS) begin : g_used
      assign flag[i] = (state_q[i] == StLatched);
    end else begin : g_tied
      assign flag[i] = 1'b0;
    end
  end

  // Commit captures the pre-shift shadow, so a coincident shift is not lost nor committed early.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (shift_edge) begin
      shadow_d  = {cfg_bit, shadow_q[CfgW-1:1]};
      pending_d = 1'b1;
    end
    if (commit_edge) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    logic entered;
    entered = 1'b0;
    any_d   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (clear) begin
        state_d[i] = StIdle;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (active_q[3*i+2] && x[i]) state_d[i] = DebounceEn ? StArmed : StLatched;
          end
          StArmed: begin
            if (!active_q[3*i+2] || !x[i]) state_d[i] = StIdle;
            else                           state_d[i] = StLatched;
          end
          StLatched: state_d[i] = StLatched;
          default:   state_d[i] = StIdle;
        endcase
      end
      if (state_d[i] == StLatched && state_q[i] != StLatched) entered = 1'b1;
      if (state_d[i] == StLatched) any_d = 1'b1;
    end
    evt_tgl_d = evt_tgl_q ^ entered;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      active_q      <= '0;
      shift_prev_q  <= 1'b0;
      commit_prev_q <= 1'b0;
      pending_q     <= 1'b0;
      x0_q          <= 1'b0;
      evt_tgl_q     <= 1'b0;
      any_q         <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= StIdle;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shift_prev_q  <= cfg_shift;
      commit_prev_q <= cfg_commit;
      pending_q     <= pending_d;
      x0_q          <= x[0];
      evt_tgl_q     <= evt_tgl_d;
      any_q         <= any_d;
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  assign io_out = {evt_tgl_q, x0_q, pending_q, any_q, flag};

endmodule

// File: tb/tb_mux_latch_bank.sv
// Randomized bench for mux_latch_bank against a run-length based reference model.
module tb_mux_latch_bank;

`ifdef LATCH_DEBOUNCE_EN
  localparam int Need = 2;
`else
  localparam int Need = 1;
`endif

  logic       clk;
  logic       rst, a, b, cfg_bit, cfg_shift, cfg_commit, clear;
  logic [7:0] io_in, io_out;

  assign io_in = {clear, cfg_commit, cfg_shift, cfg_bit, b, a, rst, clk};

  mux_latch_bank #(.CHANNELS(4)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: config as plain integers, channels as qualifying-run lengths plus sticky latch.
  logic [11:0] m_shadow, m_active;
  int          m_run [4];
  bit          m_lat [4];
  bit          m_pend, m_x0, m_tgl, m_shp, m_cmp;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit newly;
    bit xs [4];
    for (int i = 0; i < 4; i++) xs[i] = (m_active[3*i] ? b : a) ^ m_active[3*i+1];
    if (rst) begin
      m_shadow = 0; m_active = 0; m_pend = 0; m_x0 = 0; m_tgl = 0; m_shp = 0; m_cmp = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_lat[i] = 0; end
      return;
    end
    newly = 0;
    for (int i = 0; i < 4; i++) begin
      if (clear) begin
        m_run[i] = 0; m_lat[i] = 0;
      end else if (!m_lat[i]) begin
        if (m_active[3*i+2] && xs[i]) begin
          m_run[i]++;
          if (m_run[i] >= Need) begin m_lat[i] = 1; newly = 1; end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (newly) m_tgl = !m_tgl;
    m_x0 = xs[0];
    if (cfg_commit && !m_cmp) begin
      m_active = m_shadow;
      m_pend   = 0;
    end else if (cfg_shift && !m_shp) begin
      m_pend = 1;
    end
    if (cfg_shift && !m_shp) m_shadow = (m_shadow >> 1) | (12'(cfg_bit) << 11);
    m_shp = cfg_shift;
    m_cmp = cfg_commit;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = m_lat[i];
    return {m_tgl, m_x0, m_pend, |f, f};
  endfunction

  task automatic step(input logic r, input logic ia, input logic ib, input logic cb,
                      input logic sh, input logic cm, input logic clr, input string tag);
    @(negedge clk);
    rst = r; a = ia; b = ib; cfg_bit = cb; cfg_shift = sh; cfg_commit = cm; clear = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_eq(tag, io_out, model_out());
  endtask

  task automatic load_cfg(input logic [11:0] v);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, v[k], 0, 0, 0, "shift_lo");
      step(0, 0, 0, v[k], 1, 0, 0, "shift_hi");
    end
    step(0, 0, 0, 0, 0, 1, 0, "commit");
    step(0, 0, 0, 0, 0, 0, 0, "post_commit");
  endtask

  initial begin
    rst = 1; a = 0; b = 0; cfg_bit = 0; cfg_shift = 0; cfg_commit = 0; clear = 0;
    step(1, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 1, 1, 0, 0, 0, "reset_hold");
    check_eq("reset_out", io_out, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, "idle");
    check_eq("idle_out", io_out, 8'h00);

    // ch0 = {en=1, inv=0, sel=0}
    load_cfg(12'h004);
    check_eq("cfg_quiet", io_out, 8'h00);
    step(0, 1, 0, 0, 0, 0, 0, "a1_first");
    step(0, 1, 0, 0, 0, 0, 0, "a1_second");
    step(0, 0, 0, 0, 0, 0, 1, "clear");
    step(0, 1, 0, 0, 0, 0, 0, "glitch");
    step(0, 0, 0, 0, 0, 0, 0, "glitch_off");
    step(0, 0, 0, 0, 0, 0, 0, "glitch_idle");

    // ch0 en, ch1 {en,inv,sel}, ch2 en: all qualify together with a=1, b=0
    load_cfg(12'h13C);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0, "multi");
    step(0, 1, 0, 0, 0, 0, 1, "multi_clear");
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0, "relatch");
    // Coincident shift and commit edges
    step(0, 1, 0, 1, 1, 1, 0, "shift_commit");
    step(0, 1, 0, 0, 0, 0, 0, "after_sc");
    step(0, 0, 0, 1, 1, 0, 0, "pend");
    step(1, 1, 0, 0, 0, 0, 0, "reset_latched");
    check_eq("reset_latched_out", io_out, 8'h00);
    step(0, 1, 0, 0, 0, 0, 0, "no_cfg_a1");
    step(0, 1, 0, 0, 0, 0, 0, "no_cfg_a1b");

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
